// File: rtl/regfile_mp_pkg.sv
// Shared definitions for the multi-port register file with busy scoreboard.
// Holds the address-width helper, the size defaults and the
// highest-index-wins port selector used by both the write path and the
// optional read bypass (enabled by REGFILE_MP_SB_BYPASS_EN in the top level).
package regfile_mp_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 32;

    // Upper bound on write ports handled by the port selector below.
    localparam int MAX_PORTS = 32;

    // Address width for a given register count; never narrower than one bit.
    function automatic int aw_of(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Index of the highest set bit in a per-port hit vector. Callers only use
    // the result when at least one bit is set.
    function automatic int hi_win(input logic [MAX_PORTS-1:0] hits);
        int w;
        w = 0;
        for (int k = 0; k < MAX_PORTS; k++) begin
            if (hits[k]) w = k;
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits. A reserve marks a register as awaiting a new
// producer; a write retires the pending producer unless a reserve for the same
// register arrives on the same edge, in which case the register stays busy.
// With ZERO_R0 set, register 0 is never busy.
module regfile_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int NW      = 2,
    parameter  int ZERO_R0 = 0,
    localparam int AW      = aw_of(DEPTH)
) (
    input  logic             clk,
    input  logic             cr,
    input  logic [NW-1:0]    we,
    input  logic [NW*AW-1:0] waddr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [DEPTH-1:0] busy_vec
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_hit;

    // Next busy state: reserve beats write, write clears, otherwise hold.
    always_comb begin
        busy_d = busy_q;
        wr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit = 1'b0;
            for (int k = 0; k < NW; k++) begin
                if (we[k] && (waddr[k*AW +: AW] == AW'(i))) wr_hit = 1'b1;
            end
            if (rsv_en && (rsv_addr == AW'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_hit) begin
                busy_d[i] = 1'b0;
            end
        end
        if (ZERO_R0 != 0) busy_d[0] = 1'b0;
    end

    // Busy state register, cleared asynchronously.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with per-register busy scoreboard.
// Writes land on the rising edge; when several ports hit one address the
// highest-index port wins. Reads are combinational.
// Optional macro REGFILE_MP_SB_BYPASS_EN: forward same-cycle write data (and
// the post-edge busy value) to read ports addressing a register being written.
module regfile_mp_sb
    import regfile_mp_pkg::*;
#(
    parameter  int DEPTH   = DEPTH_DEF,
    parameter  int WIDTH   = WIDTH_DEF,
    parameter  int NW      = 2,
    parameter  int NR      = 2,
    parameter  int ZERO_R0 = 0,
    localparam int AW      = aw_of(DEPTH)
) (
    input  logic                clk,
    input  logic                cr,
    input  logic [NW-1:0]       we,
    input  logic [NW*AW-1:0]    waddr,
    input  logic [NW*WIDTH-1:0] wdata,
    input  logic [NR*AW-1:0]    raddr,
    output logic [NR*WIDTH-1:0] rdata,
    output logic [NR-1:0]       rbusy,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr,
    output logic [DEPTH-1:0]    busy_vec
);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [MAX_PORTS-1:0] whits;
    logic [AW-1:0]        ra;
`ifdef REGFILE_MP_SB_BYPASS_EN
    logic [MAX_PORTS-1:0] rhits;
`endif

    regfile_scoreboard #(
        .DEPTH   (DEPTH),
        .NW      (NW),
        .ZERO_R0 (ZERO_R0)
    ) u_scoreboard (
        .clk      (clk),
        .cr       (cr),
        .we       (we),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy_vec (busy_vec)
    );

    // Write decode: each register takes the data of its highest-index writer.
    always_comb begin
        whits = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            whits    = '0;
            for (int k = 0; k < NW; k++) begin
                whits[k] = we[k] && (waddr[k*AW +: AW] == AW'(i));
            end
            if ((|whits) && !((ZERO_R0 != 0) && (i == 0))) begin
                mem_d[i] = wdata[hi_win(whits)*WIDTH +: WIDTH];
            end
        end
    end

    // Storage array, cleared asynchronously.
    always_ff @(posedge clk or negedge cr) begin
        if (!cr) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // Read muxes: stored value and busy bit, optionally overridden by bypass.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
`ifdef REGFILE_MP_SB_BYPASS_EN
        rhits = '0;
`endif
        for (int j = 0; j < NR; j++) begin
            ra = raddr[j*AW +: AW];
            rdata[j*WIDTH +: WIDTH] = mem_q[ra];
            rbusy[j]                = busy_vec[ra];
            if ((ZERO_R0 != 0) && (ra == '0)) begin
                rdata[j*WIDTH +: WIDTH] = '0;
            end
`ifdef REGFILE_MP_SB_BYPASS_EN
            rhits = '0;
            for (int k = 0; k < NW; k++) begin
                rhits[k] = we[k] && (waddr[k*AW +: AW] == ra);
            end
            if ((|rhits) && !((ZERO_R0 != 0) && (ra == '0))) begin
                rdata[j*WIDTH +: WIDTH] = wdata[hi_win(rhits)*WIDTH +: WIDTH];
                rbusy[j]                = rsv_en && (rsv_addr == ra);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: a ZERO_R0=0 and a ZERO_R0=1 instance
// share stimulus; a behavioural model predicts contents and busy bits.
module tb_regfile_mp_sb;

    logic        clk;
    logic        cr;
    logic [1:0]  we;
    logic [5:0]  waddr;
    logic [63:0] wdata;
    logic [5:0]  raddr;
    logic        rsv_en;
    logic [2:0]  rsv_addr;
    logic [63:0] rdata,  rdata_z;
    logic [1:0]  rbusy,  rbusy_z;
    logic [7:0]  busy_vec, busy_vec_z;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl  [8];
    logic [31:0] mdlz [8];
    logic [7:0]  bsy, bsyz;

    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    regfile_mp_sb #(.DEPTH(8), .WIDTH(32), .NW(2), .NR(2), .ZERO_R0(0)) dut (
        .clk(clk), .cr(cr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec)
    );

    regfile_mp_sb #(.DEPTH(8), .WIDTH(32), .NW(2), .NR(2), .ZERO_R0(1)) dut_z (
        .clk(clk), .cr(cr), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_z), .rbusy(rbusy_z),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .busy_vec(busy_vec_z)
    );

    // Clock
    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 8; a++) begin
            mdl[a]  = '0;
            mdlz[a] = '0;
        end
        bsy  = '0;
        bsyz = '0;
    endtask

    task automatic idle_inputs();
        we       = '0;
        waddr    = '0;
        wdata    = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
    endtask

    task automatic drive_write(input int p, input int addr, input logic [31:0] d);
        we[p]             = 1'b1;
        waddr[p*3 +: 3]   = 3'(addr);
        wdata[p*32 +: 32] = d;
    endtask

    task automatic drive_reserve(input int addr);
        rsv_en   = 1'b1;
        rsv_addr = 3'(addr);
    endtask

    // Predict the edge, take it, then return inputs to idle.
    task automatic tick();
        logic [31:0] nm [8];
        logic [31:0] nz [8];
        logic [7:0]  nb, nbz;
        logic        hit;
        logic [31:0] wd;
        for (int a = 0; a < 8; a++) begin
            hit = 1'b0;
            wd  = '0;
            for (int k = 0; k < 2; k++) begin
                if (we[k] && (waddr[k*3 +: 3] == 3'(a))) begin
                    hit = 1'b1;
                    wd  = wdata[k*32 +: 32];
                end
            end
            nm[a] = hit ? wd : mdl[a];
            nz[a] = (hit && a != 0) ? wd : mdlz[a];
            if (rsv_en && rsv_addr == 3'(a)) nb[a] = 1'b1;
            else if (hit)                    nb[a] = 1'b0;
            else                             nb[a] = bsy[a];
            nbz[a] = (a == 0) ? 1'b0 : nb[a];
        end
        @(posedge clk);
        #1;
        for (int a = 0; a < 8; a++) begin
            mdl[a]  = nm[a];
            mdlz[a] = nz[a];
        end
        bsy  = nb;
        bsyz = nbz;
        idle_inputs();
    endtask

    // Sweep every address on both read ports of both instances.
    task automatic check_all(input string tag);
        for (int a = 0; a < 8; a++) begin
            raddr = {3'(7 - a), 3'(a)};
            exp_q.push_back(mdl[a]);
            exp_q.push_back(mdl[7-a]);
            exp_q.push_back(mdlz[a]);
            #1;
            got_q.push_back(rdata[31:0]);
            got_q.push_back(rdata[63:32]);
            got_q.push_back(rdata_z[31:0]);
            while (exp_q.size() > 0 && got_q.size() > 0) begin
                check({tag, "_rdata"}, 64'(got_q.pop_front()), 64'(exp_q.pop_front()));
            end
            check({tag, "_rbusy0"}, 64'(rbusy[0]), 64'(bsy[a]));
            check({tag, "_rbusy1"}, 64'(rbusy[1]), 64'(bsy[7-a]));
            check({tag, "_rbusyz"}, 64'(rbusy_z[0]), 64'(bsyz[a]));
        end
        check({tag, "_busy_vec"},   64'(busy_vec),   64'(bsy));
        check({tag, "_busy_vec_z"}, 64'(busy_vec_z), 64'(bsyz));
    endtask

    initial begin
        cr    = 1'b0;
        raddr = '0;
        idle_inputs();
        model_reset();
        #5;
        check_all("reset");
        @(negedge clk);
        cr = 1'b1;
        @(posedge clk);
        #1;

        // Dual write to distinct registers
        drive_write(0, 1, 32'hA5A5_A5A5);
        drive_write(1, 6, 32'h5A5A_5A5A);
        tick();
        raddr = {3'd6, 3'd1};
        #1;
        check("dual_qa", 64'(rdata[31:0]),  64'h0000_0000_A5A5_A5A5);
        check("dual_qb", 64'(rdata[63:32]), 64'h0000_0000_5A5A_5A5A);
        check_all("dual");

        // Write conflict: highest-index port wins
        drive_write(0, 3, 32'h1111_1111);
        drive_write(1, 3, 32'h2222_2222);
        tick();
        raddr = {3'd0, 3'd3};
        #1;
        check("conflict", 64'(rdata[31:0]), 64'h0000_0000_2222_2222);
        check_all("conflict");

        // Scoreboard reserve, release, and reserve-with-write
        drive_reserve(5);
        tick();
        check("rsv_r5", 64'(busy_vec), 64'h20);
        drive_reserve(5);
        tick();
        check("rsv_again", 64'(busy_vec), 64'h20);
        drive_write(0, 5, 32'h0000_0055);
        tick();
        check("release_r5", 64'(busy_vec), 64'h00);
        drive_reserve(5);
        drive_write(1, 5, 32'h0000_0077);
        tick();
        check("rsv_wr_busy", 64'(busy_vec), 64'h20);
        raddr = {3'd5, 3'd5};
        #1;
        check("rsv_wr_data", 64'(rdata[31:0]), 64'h0000_0000_0000_0077);
        drive_write(0, 2, 32'h0000_0099);
        tick();
        check("wr_nonbusy", 64'(busy_vec), 64'h20);
        check_all("scoreboard");

        // Register 0 write and reserve
        drive_write(0, 0, 32'hDEAD_BEEF);
        drive_reserve(0);
        tick();
        raddr = {3'd0, 3'd0};
        #1;
        check("zero_rdata", 64'(rdata_z[31:0]), 64'h0);
        check("zero_busy",  64'(busy_vec_z[0]), 64'h0);
        check("nz_r0_data", 64'(rdata[31:0]),   64'h0000_0000_DEAD_BEEF);
        check("nz_r0_busy", 64'(busy_vec[0]),   64'h1);
        check_all("zero");

        // Same-cycle read of a register being written
        drive_write(0, 2, 32'h1234_5678);
        raddr = {3'd2, 3'd0};
        #1;
`ifdef REGFILE_MP_SB_BYPASS_EN
        check("bypass_same", 64'(rdata[63:32]), 64'h0000_0000_1234_5678);
        check("bypass_busy", 64'(rbusy[1]), 64'h0);
`else
        check("bypass_same", 64'(rdata[63:32]), 64'h0000_0000_0000_0099);
`endif
        tick();
        raddr = {3'd2, 3'd0};
        #1;
        check("bypass_next", 64'(rdata[63:32]), 64'h0000_0000_1234_5678);

        // Random traffic
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 1) == 1) drive_write(0, $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 1) == 1) drive_write(1, $urandom_range(0, 7), $urandom);
            if ($urandom_range(0, 2) == 0) drive_reserve($urandom_range(0, 7));
            tick();
            check_all("random");
        end

        // Reset asserted mid-cycle with a write and reserve pending
        drive_write(0, 4, 32'hCAFE_F00D);
        drive_write(1, 7, 32'hBEEF_0001);
        drive_reserve(4);
        #2;
        cr = 1'b0;
        model_reset();
        #1;
        check_all("mid_reset");
        @(posedge clk);
        #1;
        idle_inputs();
        check_all("reset_hold");
        @(negedge clk);
        cr = 1'b1;
        drive_write(1, 7, 32'h0000_0707);
        tick();
        check_all("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
